// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulator pipeline.
// Holds the accumulator FSM encoding used by mac_acc_pipe.
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/mul_booth_radix4.sv
// Combinational radix-4 Booth multiplier, signed or unsigned operands.
// Operands are widened by one bit so unsigned values recode as positive.
module mul_booth_radix4 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                sgn,
  output logic [2*DATA_W-1:0] p
);

  localparam int EW = DATA_W + 1 + ((DATA_W + 1) % 2);
  localparam int PW = 2 * EW;
  localparam int ND = EW / 2;

  logic [EW-1:0] a_x;
  logic [EW-1:0] b_x;
  logic [EW:0]   b_t;
  logic [PW-1:0] a_p;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum;

  assign a_x = {{(EW-DATA_W){sgn & a[DATA_W-1]}}, a};
  assign b_x = {{(EW-DATA_W){sgn & b[DATA_W-1]}}, b};
  assign a_p = {{(PW-EW){a_x[EW-1]}}, a_x};
  assign b_t = {b_x, 1'b0};

  // Recode multiplier in overlapping triplets and sum shifted partials.
  always_comb begin
    sum = '0;
    pp  = '0;
    for (int i = 0; i < ND; i++) begin
      unique case (b_t[2*i +: 3])
        3'b001, 3'b010: pp = a_p;
        3'b011:         pp = a_p << 1;
        3'b100:         pp = -(a_p << 1);
        3'b101, 3'b110: pp = -a_p;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2 * i));
    end
  end

  assign p = sum[2*DATA_W-1:0];

endmodule

// File: rtl/mac_acc_pipe.sv
// Three-stage multiply-accumulate pipeline producing dot products.
// Operand reg, product reg, accumulator with a single output register.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  logic stall;
  logic adv;

  logic              s0_v;
  logic              s0_sgn;
  logic              s0_last;
  logic [DATA_W-1:0] s0_a;
  logic [DATA_W-1:0] s0_b;

  logic [2*DATA_W-1:0] mul_p;
  logic [ACC_W-1:0]    mul_x;

  logic             s1_v;
  logic             s1_sgn;
  logic             s1_last;
  logic [ACC_W-1:0] s1_p;

  acc_state_t       state;
  acc_state_t       state_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic             aovf;
  logic             aovf_nx;
  logic [CNT_W-1:0] acnt;
  logic [CNT_W-1:0] acnt_nx;

  logic [ACC_W:0]   add_full;
  logic             add_ovf;
  logic [ACC_W-1:0] nsum;
  logic             novf;
  logic [CNT_W-1:0] ncnt;
  logic             ld_out;

  assign stall    = out_valid & ~out_ready;
  assign adv      = s1_v & ~stall;
  assign in_ready = rst_n & ~stall;

  // Operand register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_v    <= 1'b0;
      s0_sgn  <= 1'b0;
      s0_last <= 1'b0;
      s0_a    <= '0;
      s0_b    <= '0;
    end else if (!stall) begin
      s0_v    <= in_valid;
      s0_sgn  <= in_signed;
      s0_last <= in_last;
      s0_a    <= in_a;
      s0_b    <= in_b;
    end
  end

  mul_booth_radix4 #(
    .DATA_W(DATA_W)
  ) u_mul (
    .a  (s0_a),
    .b  (s0_b),
    .sgn(s0_sgn),
    .p  (mul_p)
  );

  // Extend the exact product to accumulator width in the beat's mode.
  always_comb begin
    mul_x = {ACC_W{s0_sgn & mul_p[2*DATA_W-1]}};
    mul_x[2*DATA_W-1:0] = mul_p;
  end

  // Product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_last <= 1'b0;
      s1_p    <= '0;
    end else if (!stall) begin
      s1_v    <= s0_v;
      s1_sgn  <= s0_sgn;
      s1_last <= s0_last;
      s1_p    <= mul_x;
    end
  end

  // Accumulator next-state: partial sum, sticky overflow, beat count.
  always_comb begin
    add_full = {1'b0, acc} + {1'b0, s1_p};
    add_ovf  = s1_sgn
             ? ((acc[ACC_W-1] == s1_p[ACC_W-1]) &&
                (add_full[ACC_W-1] != acc[ACC_W-1]))
             : add_full[ACC_W];
    nsum     = s1_p;
    novf     = 1'b0;
    ncnt     = CNT_W'(1);
    state_nx = state;
    acc_nx   = acc;
    aovf_nx  = aovf;
    acnt_nx  = acnt;
    ld_out   = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        nsum = add_full[ACC_W-1:0];
        novf = aovf | add_ovf;
        ncnt = (&acnt) ? acnt : acnt + CNT_W'(1);
      end
    endcase
    if (adv) begin
      if (s1_last) begin
        state_nx = IDLE;
        acc_nx   = '0;
        aovf_nx  = 1'b0;
        acnt_nx  = '0;
        ld_out   = 1'b1;
      end else begin
        state_nx = RUN;
        acc_nx   = nsum;
        aovf_nx  = novf;
        acnt_nx  = ncnt;
      end
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      aovf  <= 1'b0;
      acnt  <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      aovf  <= aovf_nx;
      acnt  <= acnt_nx;
    end
  end

  // Output register reloads in the same cycle it is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (ld_out) begin
      out_valid <= 1'b1;
      out_data  <= nsum;
      out_ovf   <= novf;
      out_cnt   <= ncnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: directed cases plus random traffic
// against a dot-product model, for ACC_W=32 and ACC_W=16 copies.
module tb_mac_acc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic [15:0] out_cnt;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;
  logic [15:0] out_cnt16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.DATA_W(8), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  mac_acc_pipe #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_ovf(out_ovf16), .out_cnt(out_cnt16)
  );

  typedef struct {
    longint d;
    bit     o;
    int     c;
  } res_t;

  res_t   q0[$];
  res_t   q1[$];
  bit     busy[2];
  longint macc[2];
  bit     movf[2];
  int     mcnt[2];
  int     aw[2] = '{32, 16};

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Dot-product model in plain integer arithmetic.
  function automatic void mdl_beat(input int k, input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic sg, input logic last);
    longint md;
    longint p;
    longint s;
    longint as;
    res_t   r;
    md = 64'sd1 <<< aw[k];
    if (sg) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    if (!busy[k]) begin
      macc[k] = ((p % md) + md) % md;
      movf[k] = 1'b0;
      mcnt[k] = 1;
    end else begin
      if (sg) begin
        as = (macc[k] >= md / 2) ? macc[k] - md : macc[k];
        s  = as + p;
        if (s >= md / 2 || s < -(md / 2)) movf[k] = 1'b1;
      end else begin
        if (macc[k] + p >= md) movf[k] = 1'b1;
      end
      macc[k] = (((macc[k] + p) % md) + md) % md;
      if (mcnt[k] < 65535) mcnt[k]++;
    end
    if (last) begin
      r.d = macc[k];
      r.o = movf[k];
      r.c = mcnt[k];
      if (k == 0) q0.push_back(r);
      else        q1.push_back(r);
      busy[k] = 1'b0;
    end else begin
      busy[k] = 1'b1;
    end
  endfunction

  logic [31:0] pd;
  logic [15:0] pd16;
  logic [15:0] pc;
  logic        po;
  bit          pstall = 1'b0;

  // Compare process: runs every cycle, ahead of the next rising edge.
  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      q0.delete();
      q1.delete();
      pstall = 1'b0;
      chk("in_ready_in_reset", in_ready, 0);
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("in_ready16", in_ready16, in_ready);
      if (pstall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_ovf", out_ovf, po);
        chk("stall_cnt", out_cnt, pc);
        chk("stall_data16", out_data16, pd16);
      end
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          r = q0.pop_front();
          chk("res_data", out_data, r.d);
          chk("res_ovf", out_ovf, r.o);
          chk("res_cnt", out_cnt, r.c);
        end
      end
      if (out_valid16 && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_result16", 1, 0);
        end else begin
          r = q1.pop_front();
          chk("res_data16", out_data16, r.d);
          chk("res_ovf16", out_ovf16, r.o);
          chk("res_cnt16", out_cnt16, r.c);
        end
      end
      if (in_valid && in_ready) begin
        mdl_beat(0, in_a, in_b, in_signed, in_last);
        mdl_beat(1, in_a, in_b, in_signed, in_last);
      end
      pstall = out_valid && !out_ready;
      pd     = out_data;
      pd16   = out_data16;
      po     = out_ovf;
      pc     = out_cnt;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic sg, input logic lst);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sg;
    in_last   = lst;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    if (!ok) chk(nm, 0, 1);
  endtask

  task automatic expect_res(input string nm, input longint d,
                            input bit o, input int c);
    int n;
    n = 0;
    while (!(out_valid && out_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(out_valid && out_ready)) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_data"}, out_data, d);
      chk({nm, "_ovf"}, out_ovf, o);
      chk({nm, "_cnt"}, out_cnt, c);
    end
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_valid16", out_valid16, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);
    sync();

    send(8'h80, 8'h80, 1'b1, 1'b0);
    send(8'd127, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_e0", out_valid, 0);
    @(negedge clk);
    chk("lat_e1", out_valid, 0);
    @(negedge clk);
    chk("lat_e2", out_valid, 1);
    chk("sgn2_data", out_data, 16257);
    chk("sgn2_cnt", out_cnt, 2);
    chk("sgn2_ovf", out_ovf, 0);
    sync();

    send(8'd255, 8'd255, 1'b0, 1'b1);
    expect_res("u255", 65025, 1'b0, 1);

    send(8'h80, 8'h80, 1'b1, 1'b0);
    send(8'h80, 8'h80, 1'b1, 1'b0);
    send(8'h80, 8'h80, 1'b1, 1'b1);
    wait_valid("acc16_timeout", ok);
    if (ok) begin
      chk("acc16_data", out_data16, 16'hC000);
      chk("acc16_ovf", out_ovf16, 1);
      chk("acc16_cnt", out_cnt16, 3);
      chk("acc32_data", out_data, 49152);
      chk("acc32_ovf", out_ovf, 0);
    end
    sync();

    out_ready = 1'b0;
    send(8'd7, 8'd7, 1'b0, 1'b1);
    fork
      begin
        send(8'd2, 8'd3, 1'b0, 1'b0);
        send(8'd4, 8'd5, 1'b0, 1'b1);
        send(8'd9, 8'd9, 1'b0, 1'b1);
      end
    join_none
    wait_valid("stall_timeout", ok);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", out_data, 49);
      @(negedge clk);
    end
    sync();
    out_ready = 1'b1;
    expect_res("stall_first", 49, 1'b0, 1);
    expect_res("after_stall", 26, 1'b0, 2);
    expect_res("after_stall2", 81, 1'b0, 1);
    wait fork;
    sync();

    send(8'd10, 8'd10, 1'b0, 1'b0);
    send(8'd10, 8'd10, 1'b0, 1'b0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    send(8'd3, 8'd4, 1'b0, 1'b1);
    expect_res("abort", 12, 1'b0, 1);

    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(8'(k), 8'(k), 1'b0, 1'b1);
      end
      begin
        wait_valid("b2b_timeout", ok);
        for (int k = 1; k <= 8; k++) begin
          chk("b2b_valid", out_valid, 1);
          chk("b2b_data", out_data, k * k);
          @(negedge clk);
        end
      end
    join
    sync();

    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_signed = 1'($urandom);
      in_last   = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 3) != 0);
      sync();
    end

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q0.size() != 0 || out_valid) && n < 50) begin
      sync();
      n++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
